// File: rtl/bus_sequencer.sv
// bus_sequencer: sequences the 4-bit multiplexed external bus across the
// 8-subcycle system cycle (A1,A2,A3,M1,M2,X1,X2,X3). Drives the address
// nibbles, CM-ROM/CM-RAM strobes and the PC increment pulse, and runs the
// two-system-cycle FIN sequence (ROM addressed from pair 0, fetched byte
// written into the pair selected by the FIN opcode).
//
// Ports:
//   clock      : system clock
//   reset      : synchronous, active-high reset
//   cycle      : subcycle index (0=A1 .. 7=X3)
//   inst       : latched instruction byte
//   two_word   : current system cycle is the second word of a 2-word inst
//   pc         : current program counter
//   pair0      : register pair 0 {r0,r1}
//   pair_sel   : register pair addressed by inst[3:1]
//   bus_out    : nibble driven onto the data bus
//   bus_oe     : bus_out drive enable
//   cm_rom     : ROM command strobe
//   cm_ram     : RAM command strobe
//   pc_inc     : one-subcycle PC increment pulse
//   fin_active : high for the whole FIN fetch system cycle
//   fin_write  : register file write enable for fetched data
//   fin_low    : 0 = high nibble to even reg, 1 = low nibble to odd reg
module bus_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  cycle,
  input  logic [7:0]  inst,
  input  logic        two_word,
  input  logic [11:0] pc,
  input  logic [7:0]  pair0,
  input  logic [7:0]  pair_sel,
  output logic [3:0]  bus_out,
  output logic        bus_oe,
  output logic        cm_rom,
  output logic        cm_ram,
  output logic        pc_inc,
  output logic        fin_active,
  output logic        fin_write,
  output logic        fin_low
);

  localparam int unsigned ADDR_W = 12;

  localparam logic [2:0] CYC_A1 = 3'd0;
  localparam logic [2:0] CYC_A2 = 3'd1;
  localparam logic [2:0] CYC_A3 = 3'd2;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  localparam logic [3:0] OPR_FIN_SRC = 4'h3;
  localparam logic [3:0] OPR_SRC     = 4'h2;
  localparam logic [3:0] OPR_IO      = 4'hE;

  typedef enum logic {
    NORMAL    = 1'b0,
    FIN_FETCH = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic              is_fin;
  logic              is_src;
  logic [ADDR_W-1:0] addr;

  // Pair index bits are consumed by the register file, not here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[3:1];

  // FIN/SRC decode; a second-word byte is data, never an opcode.
  assign is_fin = (inst[7:4] == OPR_FIN_SRC) && !inst[0] && !two_word;
  assign is_src = (inst[7:4] == OPR_SRC) && inst[0] && !two_word;

  // FIN fetches through pair 0 within the current ROM page.
  assign addr = (state == FIN_FETCH) ? {pc[11:8], pair0} : pc;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= NORMAL;
    else       state <= state_nxt;
  end

  // Next state: advances only at the X3 boundary
  always_comb begin
    state_nxt = state;
    if (cycle == CYC_X3) begin
      case (state)
        NORMAL:    if (is_fin) state_nxt = FIN_FETCH;
        FIN_FETCH: state_nxt = NORMAL;
        default:   state_nxt = NORMAL;
      endcase
    end
  end

  // Per-subcycle bus, strobe and FIN outputs, all forced low under reset
  always_comb begin
    bus_out    = 4'h0;
    bus_oe     = 1'b0;
    cm_rom     = 1'b0;
    cm_ram     = 1'b0;
    pc_inc     = 1'b0;
    fin_active = 1'b0;
    fin_write  = 1'b0;
    fin_low    = 1'b0;
    if (!reset) begin
      case (cycle)
        CYC_A1: begin
          bus_out = addr[3:0];
          bus_oe  = 1'b1;
        end
        CYC_A2: begin
          bus_out = addr[7:4];
          bus_oe  = 1'b1;
        end
        CYC_A3: begin
          bus_out = addr[11:8];
          bus_oe  = 1'b1;
          cm_rom  = 1'b1;
          cm_ram  = 1'b1;
          pc_inc  = (state == NORMAL);
        end
        CYC_M2: begin
          if (state == NORMAL && inst[7:4] == OPR_IO) begin
            cm_rom = 1'b1;
            cm_ram = 1'b1;
          end
        end
        CYC_X2: begin
          if (state == NORMAL && is_src) begin
            bus_out = pair_sel[7:4];
            bus_oe  = 1'b1;
            cm_rom  = 1'b1;
            cm_ram  = 1'b1;
          end
        end
        CYC_X3: begin
          if (state == NORMAL && is_src) begin
            bus_out = pair_sel[3:0];
            bus_oe  = 1'b1;
          end
        end
        default: ;
      endcase

      if (state == FIN_FETCH) begin
        fin_active = 1'b1;
        // ROM data appears on M1 (high nibble) then M2 (low nibble)
        if (cycle == CYC_M1) begin
          fin_write = 1'b1;
          fin_low   = 1'b0;
        end else if (cycle == CYC_M2) begin
          fin_write = 1'b1;
          fin_low   = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed table-driven bench for bus_sequencer.
module tb_bus_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  cycle;
  logic [7:0]  inst;
  logic        two_word;
  logic [11:0] pc;
  logic [7:0]  pair0;
  logic [7:0]  pair_sel;
  logic [3:0]  bus_out;
  logic        bus_oe, cm_rom, cm_ram, pc_inc, fin_active, fin_write, fin_low;

  bus_sequencer dut (
    .clock(clock), .reset(reset), .cycle(cycle), .inst(inst),
    .two_word(two_word), .pc(pc), .pair0(pair0), .pair_sel(pair_sel),
    .bus_out(bus_out), .bus_oe(bus_oe), .cm_rom(cm_rom), .cm_ram(cm_ram),
    .pc_inc(pc_inc), .fin_active(fin_active), .fin_write(fin_write),
    .fin_low(fin_low)
  );

  always #5 clock = ~clock;

  // Expected flag bits, packed below the 4-bit bus value
  localparam logic [6:0] NO  = 7'b0000000;
  localparam logic [6:0] OE  = 7'b1000000;
  localparam logic [6:0] ST  = 7'b0110000;
  localparam logic [6:0] INC = 7'b0001000;
  localparam logic [6:0] FA  = 7'b0000100;
  localparam logic [6:0] FW  = 7'b0000010;
  localparam logic [6:0] FL  = 7'b0000001;

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  cyc;
    logic [7:0]  inst;
    logic        tw;
    logic [11:0] pc;
    logic [7:0]  p0;
    logic [7:0]  ps;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0]  c_inst;
  logic        c_tw;
  logic [11:0] c_pc;
  logic [7:0]  c_p0;
  logic [7:0]  c_ps;

  task automatic ctx(input logic [7:0] i, input logic t, input logic [11:0] p,
                     input logic [7:0] a, input logic [7:0] s);
    c_inst = i; c_tw = t; c_pc = p; c_p0 = a; c_ps = s;
  endtask

  function automatic vec_t mk(input string nm, input logic r, input logic [2:0] c,
                              input logic [10:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.cyc = c; v.inst = c_inst; v.tw = c_tw;
    v.pc = c_pc; v.p0 = c_p0; v.ps = c_ps; v.exp = e;
    return v;
  endfunction

  task automatic add(input string nm, input logic r, input logic [2:0] c,
                     input logic [10:0] e);
    vecs.push_back(mk(nm, r, c, e));
  endtask

  // Drive one subcycle mid-period, check settled outputs, then let the edge go
  task automatic apply(input vec_t v);
    logic [10:0] got;
    @(negedge clock);
    reset = v.rst; cycle = v.cyc; inst = v.inst; two_word = v.tw;
    pc = v.pc; pair0 = v.p0; pair_sel = v.ps;
    #2;
    got = {bus_out, bus_oe, cm_rom, cm_ram, pc_inc, fin_active, fin_write, fin_low};
    n_tests++;
    if (got !== v.exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got={bus=%h oe,rom,ram,inc,fa,fw,fl=%b} want={bus=%h %b}",
               v.name, v.cyc, got[10:7], got[6:0], v.exp[10:7], v.exp[6:0]);
    end
  endtask

  initial begin
    reset = 1'b1; cycle = 3'd0; inst = 8'h00; two_word = 1'b0;
    pc = 12'h000; pair0 = 8'h00; pair_sel = 8'h00;

    // Reset gating: address and strobes suppressed
    ctx(8'hD5, 1'b0, 12'hABC, 8'h00, 8'h00);
    add("rst_c0", 1'b1, 3'd0, {4'h0, NO});
    add("rst_c2", 1'b1, 3'd2, {4'h0, NO});

    // Plain instruction fetch
    add("pc_c0", 1'b0, 3'd0, {4'hC, OE});
    add("pc_c1", 1'b0, 3'd1, {4'hB, OE});
    add("pc_c2", 1'b0, 3'd2, {4'hA, OE | ST | INC});
    add("pc_c3", 1'b0, 3'd3, {4'h0, NO});
    add("pc_c4", 1'b0, 3'd4, {4'h0, NO});
    add("pc_c5", 1'b0, 3'd5, {4'h0, NO});
    add("pc_c6", 1'b0, 3'd6, {4'h0, NO});
    add("pc_c7", 1'b0, 3'd7, {4'h0, NO});

    // FIN opcode cycle, then FIN fetch via pair 0
    ctx(8'h32, 1'b0, 12'h5F0, 8'h7E, 8'h00);
    add("fin_op_c0", 1'b0, 3'd0, {4'h0, OE});
    add("fin_op_c1", 1'b0, 3'd1, {4'hF, OE});
    add("fin_op_c2", 1'b0, 3'd2, {4'h5, OE | ST | INC});
    add("fin_op_c3", 1'b0, 3'd3, {4'h0, NO});
    add("fin_op_c7", 1'b0, 3'd7, {4'h0, NO});
    add("fin_c0", 1'b0, 3'd0, {4'hE, OE | FA});
    add("fin_c1", 1'b0, 3'd1, {4'h7, OE | FA});
    add("fin_c2", 1'b0, 3'd2, {4'h5, OE | ST | FA});
    add("fin_c3", 1'b0, 3'd3, {4'h0, FA | FW});
    add("fin_c4", 1'b0, 3'd4, {4'h0, FA | FW | FL});
    add("fin_c5", 1'b0, 3'd5, {4'h0, FA});
    add("fin_c6", 1'b0, 3'd6, {4'h0, FA});
    add("fin_c7", 1'b0, 3'd7, {4'h0, FA});
    // Back to NORMAL even with the FIN opcode still held
    ctx(8'h32, 1'b0, 12'h5F1, 8'h7E, 8'h00);
    add("post_fin_c0", 1'b0, 3'd0, {4'h1, OE});
    add("post_fin_c1", 1'b0, 3'd1, {4'hF, OE});
    add("post_fin_c2", 1'b0, 3'd2, {4'h5, OE | ST | INC});
    add("post_fin_c3", 1'b0, 3'd3, {4'h0, NO});
    ctx(8'h00, 1'b0, 12'h5F1, 8'h7E, 8'h00);
    add("post_fin_c7", 1'b0, 3'd7, {4'h0, NO});

    // SRC pair 1
    ctx(8'h23, 1'b0, 12'h123, 8'h00, 8'h9C);
    add("src_c0", 1'b0, 3'd0, {4'h3, OE});
    add("src_c1", 1'b0, 3'd1, {4'h2, OE});
    add("src_c2", 1'b0, 3'd2, {4'h1, OE | ST | INC});
    add("src_c3", 1'b0, 3'd3, {4'h0, NO});
    add("src_c4", 1'b0, 3'd4, {4'h0, NO});
    add("src_c5", 1'b0, 3'd5, {4'h0, NO});
    add("src_c6", 1'b0, 3'd6, {4'h9, OE | ST});
    add("src_c7", 1'b0, 3'd7, {4'hC, OE});

    // I/O instruction strobes at A3 and M2
    ctx(8'hE4, 1'b0, 12'h000, 8'h00, 8'h00);
    add("io_c0", 1'b0, 3'd0, {4'h0, OE});
    add("io_c2", 1'b0, 3'd2, {4'h0, OE | ST | INC});
    add("io_c3", 1'b0, 3'd3, {4'h0, NO});
    add("io_c4", 1'b0, 3'd4, {4'h0, ST});
    add("io_c6", 1'b0, 3'd6, {4'h0, NO});
    add("io_c7", 1'b0, 3'd7, {4'h0, NO});

    // Second-word data bytes decode as nothing
    ctx(8'h40, 1'b1, 12'h000, 8'h00, 8'h9C);
    add("tw40_c4", 1'b0, 3'd4, {4'h0, NO});
    add("tw40_c6", 1'b0, 3'd6, {4'h0, NO});
    ctx(8'h23, 1'b1, 12'h000, 8'h00, 8'h9C);
    add("tw_src_c6", 1'b0, 3'd6, {4'h0, NO});
    add("tw_src_c7", 1'b0, 3'd7, {4'h0, NO});
    ctx(8'h30, 1'b1, 12'h456, 8'h00, 8'h00);
    add("tw_fin_c7", 1'b0, 3'd7, {4'h0, NO});
    add("after_tw_c0", 1'b0, 3'd0, {4'h6, OE});
    add("after_tw_c2", 1'b0, 3'd2, {4'h4, OE | ST | INC});
    // Odd low bit is not FIN
    ctx(8'h31, 1'b0, 12'h456, 8'h00, 8'h00);
    add("odd31_c7", 1'b0, 3'd7, {4'h0, NO});
    add("after31_c0", 1'b0, 3'd0, {4'h6, OE});
    add("after31_c2", 1'b0, 3'd2, {4'h4, OE | ST | INC});

    foreach (vecs[i]) apply(vecs[i]);

    // Reset asserted at M1 of a FIN fetch
    ctx(8'h32, 1'b0, 12'h456, 8'h7E, 8'h00);
    apply(mk("rf_op_c7", 1'b0, 3'd7, {4'h0, NO}));
    apply(mk("rf_c0", 1'b0, 3'd0, {4'hE, OE | FA}));
    apply(mk("rf_c2", 1'b0, 3'd2, {4'h4, OE | ST | FA}));
    apply(mk("rf_rst_c3", 1'b1, 3'd3, {4'h0, NO}));
    ctx(8'h00, 1'b0, 12'h456, 8'h7E, 8'h00);
    apply(mk("rf_rel_c4", 1'b0, 3'd4, {4'h0, NO}));
    apply(mk("rf_rel_c5", 1'b0, 3'd5, {4'h0, NO}));
    apply(mk("rf_rel_c7", 1'b0, 3'd7, {4'h0, NO}));
    apply(mk("rf_next_c0", 1'b0, 3'd0, {4'h6, OE}));
    apply(mk("rf_next_c2", 1'b0, 3'd2, {4'h4, OE | ST | INC}));
    apply(mk("rf_next_c3", 1'b0, 3'd3, {4'h0, NO}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
